// File: rtl/s2p_pkg.sv
// Shared serial-link definitions: word/index sizes, state encoding
// and the width decode used by both receive and transmit sides.
package s2p_pkg;

  localparam int WORD_BITS = 32;
  localparam int CNT_BITS  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A width code of 0 means a full 32-bit word.
  function automatic logic [CNT_BITS:0] decode_width(
    input logic [CNT_BITS-1:0] w
  );
    return (w == '0) ? (CNT_BITS+1)'(WORD_BITS) : {1'b0, w};
  endfunction

endpackage

// File: rtl/word_hold_reg.sv
// One-entry valid/ready holding register. Ports: load/load_data in,
// ready in, valid/data out, drop pulses when a load hits a full slot.
module word_hold_reg #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         drop
);

  // Full and not draining this cycle: new word is lost, old one kept.
  assign drop = load & valid & ~ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load && (!valid || ready)) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// LSB-first serial-to-word deserializer. Ports: clock/reset, width,
// sync, in_valid/in, word_valid/word/word_ready, busy, overflow.
module serial_to_parallel #(
  parameter int WORD_BITS = 32,
  parameter int CNT_BITS  = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CNT_BITS-1:0]  width,
  input  logic                 sync,
  input  logic                 in_valid,
  input  logic                 in,
  input  logic                 word_ready,
  output logic                 word_valid,
  output logic [WORD_BITS-1:0] word,
  output logic                 busy,
  output logic                 overflow,
  input  logic                 clear_overflow
);

  import s2p_pkg::*;

  state_t                state;
  logic [CNT_BITS-1:0]   idx;
  logic [CNT_BITS:0]     eff_w;
  logic [CNT_BITS:0]     first_w;
  logic [CNT_BITS:0]     idx_nxt;
  logic [WORD_BITS-1:0]  asm_q;
  logic                  accept;
  logic                  done;
  logic [WORD_BITS-1:0]  done_word;
  logic                  drop;

  assign accept  = in_valid & ~sync;
  assign first_w = decode_width(width);
  // Widened so eff_w = 32 is reached at idx 31 before the wrap.
  assign idx_nxt = {1'b0, idx} + (CNT_BITS+1)'(1);
  assign busy    = (state == SHIFT);

  always_comb begin
    done      = 1'b0;
    done_word = '0;
    unique case (1'b1)
      accept && state == IDLE: begin
        done      = (first_w == (CNT_BITS+1)'(1));
        done_word = WORD_BITS'(in);
      end
      accept && state == SHIFT: begin
        done      = (idx_nxt == eff_w);
        done_word = asm_q | (WORD_BITS'(in) << idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      eff_w <= first_w;
      asm_q <= '0;
    end else if (sync) begin
      state <= IDLE;
      idx   <= '0;
      asm_q <= '0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!done) begin
            eff_w <= first_w;
            asm_q <= WORD_BITS'(in);
            idx   <= CNT_BITS'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (done) begin
            state <= IDLE;
            idx   <= '0;
            asm_q <= '0;
          end else begin
            asm_q[idx] <= in;
            idx        <= idx_nxt[CNT_BITS-1:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_hold_reg #(
    .W(WORD_BITS)
  ) u_hold (
    .clock     (clock),
    .reset     (reset),
    .load      (done),
    .load_data (done_word),
    .ready     (word_ready),
    .valid     (word_valid),
    .data      (word),
    .drop      (drop)
  );

  // Set wins over clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule
